// File: rtl/ro_pair_counter.sv
// Purpose : counts rising edges of two asynchronous ring-oscillator outputs over a
//           programmable clk-cycle window and compares them into one PUF response bit.
// Latency : done pulses SYNC_STAGES+2+window cycles after the cycle in which start is accepted.
// Backpr. : none; start is accepted only in IDLE, and is ignored while busy and in the done cycle.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   ro_a, ro_b        ring-oscillator outputs (asynchronous to clk)
//   start, window     one-cycle measurement request, window length in clk cycles
//   busy, done        measurement in progress, one-cycle results-valid pulse
//   count_a, count_b  edge counts of the last completed measurement
//   resp, tie, ovf    count_a > count_b, count_a == count_b, a counter overflowed
//
// Build option: define ROCNT_SAT_EN to make the counters saturate at all-ones instead of wrapping.
// SYNC_STAGES must be in the range 2..4.

module ro_pair_counter #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_a,
  input  logic             ro_b,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             resp,
  output logic             tie,
  output logic             ovf
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_COUNT  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [2:0]       SETTLE_LAST = 3'(SYNC_STAGES);
  localparam logic [2:0]       SETTLE_ONE  = 3'd1;
  localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [1:0]             state, state_nxt;
  logic [2:0]             settle_cnt;
  logic [WIN_W-1:0]       win_reg;
  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic                   hist_a, hist_b;
  logic                   edge_a, edge_b;
  logic [CNT_W-1:0]       cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
  logic                   ovf_int, ovf_nxt;

  // Synchroniser chains plus one history flop; an edge is a 0->1 step at the chain output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      hist_a <= 1'b0;
      hist_b <= 1'b0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], ro_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], ro_b};
      hist_a <= sync_a[SYNC_STAGES-1];
      hist_b <= sync_b[SYNC_STAGES-1];
    end
  end

  assign edge_a = sync_a[SYNC_STAGES-1] & ~hist_a;
  assign edge_b = sync_b[SYNC_STAGES-1] & ~hist_b;

  // win_reg is loaded with the window on start and then counts down the COUNT cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == SETTLE_LAST)
                  state_nxt = (win_reg == '0) ? S_DONE : S_COUNT;
      S_COUNT:  if (win_reg == WIN_ONE) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Edge counters. Overflow is an edge arriving while a counter is already all-ones;
  // only the increment differs between the wrapping and saturating builds.
  always_comb begin
    cnt_a_nxt = cnt_a;
    cnt_b_nxt = cnt_b;
    ovf_nxt   = ovf_int;
    if (state == S_IDLE && start) begin
      cnt_a_nxt = '0;
      cnt_b_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (state == S_COUNT) begin
      if (edge_a) begin
        if (cnt_a == '1) ovf_nxt = 1'b1;
`ifdef ROCNT_SAT_EN
        if (cnt_a != '1) cnt_a_nxt = cnt_a + CNT_ONE;
`else
        cnt_a_nxt = cnt_a + CNT_ONE;
`endif
      end
      if (edge_b) begin
        if (cnt_b == '1) ovf_nxt = 1'b1;
`ifdef ROCNT_SAT_EN
        if (cnt_b != '1) cnt_b_nxt = cnt_b + CNT_ONE;
`else
        cnt_b_nxt = cnt_b + CNT_ONE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      win_reg    <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      ovf_int    <= 1'b0;
      count_a    <= '0;
      count_b    <= '0;
      resp       <= 1'b0;
      tie        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt_a   <= cnt_a_nxt;
      cnt_b   <= cnt_b_nxt;
      ovf_int <= ovf_nxt;
      case (state)
        S_IDLE: if (start) begin
          win_reg    <= window;
          settle_cnt <= '0;
        end
        S_SETTLE: settle_cnt <= settle_cnt + SETTLE_ONE;
        S_COUNT:  win_reg    <= win_reg - WIN_ONE;
        default:  ;
      endcase
      // Results are captured on entry to DONE from the next-count values, so the
      // last COUNT cycle's edges are included and the outputs are valid with done.
      if (state_nxt == S_DONE) begin
        count_a <= cnt_a_nxt;
        count_b <= cnt_b_nxt;
        resp    <= (cnt_a_nxt > cnt_b_nxt);
        tie     <= (cnt_a_nxt == cnt_b_nxt);
        ovf     <= ovf_nxt;
      end
    end
  end

  assign busy = (state == S_SETTLE) || (state == S_COUNT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_ro_pair_counter.sv
// Purpose : randomized and directed bench for ro_pair_counter against a sample-level reference model.
// Latency : checks done at SYNC_STAGES+2+window cycles after the start cycle.
// Backpr. : none; also pulses start during a measurement and in the done cycle.

module tb_ro_pair_counter;

  localparam int CNT_W = 4;
  localparam int WIN_W = 8;
  localparam int SS    = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ro_a = 1'b0;
  logic             ro_b = 1'b0;
  logic             start = 1'b0;
  logic [WIN_W-1:0] window = '0;
  logic             busy, done, resp, tie, ovf;
  logic [CNT_W-1:0] count_a, count_b;

  ro_pair_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .ro_a(ro_a), .ro_b(ro_b), .start(start), .window(window),
    .busy(busy), .done(done), .count_a(count_a), .count_b(count_b),
    .resp(resp), .tie(tie), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // free-running cycle index used to phase the periodic RO patterns
  int ha      = 4;   // half-period of ro_a in clk cycles, 0 = random bits
  int hb      = 6;
  int last_a = 0, last_b = 0, last_ovf = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic ro_val(input int h, input int c);
    if (h == 0) return ($urandom_range(0, 1) == 1);
    return ((c / h) % 2) != 0;
  endfunction

  // Called at a negedge: drive this cycle's RO levels (sampled at the next posedge).
  task automatic drive_ro();
    ro_a = ro_val(ha, cyc);
    ro_b = ro_val(hb, cyc);
    cyc++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One measurement. The reference model: the ROs are sampled once per clk at the end of
  // each cycle; counted edges are the 0->1 steps between consecutive samples whose later
  // sample ends cycle 2..win+1 (start cycle = 0). Counts then wrap or saturate at CNT_W bits.
  task automatic measure(input int win, input int extra_start_at, input bit start_in_done);
    int  na = 0, nb = 0, ea, eb, eovf, exp_done;
    logic pa, pb;
    bit  seen = 0;
    exp_done = SS + 2 + win;
    start  = 1'b1;
    window = WIN_W'(win);
    drive_ro();
    pa = ro_a; pb = ro_b;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= exp_done + 10 && !seen; c++) begin
      drive_ro();
      if (c >= 2 && c <= win + 1) begin
        if (ro_a && !pa) na++;
        if (ro_b && !pb) nb++;
      end
      pa = ro_a; pb = ro_b;
`ifdef ROCNT_SAT_EN
      ea = (na > CMAX) ? CMAX : na;
      eb = (nb > CMAX) ? CMAX : nb;
`else
      ea = na % (CMAX + 1);
      eb = nb % (CMAX + 1);
`endif
      eovf = (na > CMAX || nb > CMAX) ? 1 : 0;
      if (done) begin
        seen = 1;
        check("latency", c, exp_done);
        check("count_a", count_a, ea);
        check("count_b", count_b, eb);
        check("resp", resp, (ea > eb) ? 1 : 0);
        check("tie", tie, (ea == eb) ? 1 : 0);
        check("ovf", ovf, eovf);
        check("busy_in_done", busy, 0);
        last_a = ea; last_b = eb; last_ovf = eovf;
      end else begin
        check("busy", busy, 1);
        if (c == SS + 2) begin
          check("hold_count_a", count_a, last_a);
          check("hold_count_b", count_b, last_b);
          check("hold_ovf", ovf, last_ovf);
        end
      end
      start = ((c == extra_start_at) || (start_in_done && c == exp_done)) ? 1'b1 : 1'b0;
      next_cycle();
    end
    if (!seen) check("done_timeout", 0, 1);
    start = 1'b0;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    drive_ro();
    next_cycle();
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) begin drive_ro(); next_cycle(); end
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count_a", count_a, 0);
    check("rst_count_b", count_b, 0);
    check("rst_resp", resp, 0);
    check("rst_tie", tie, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    drive_ro(); next_cycle();

    // Periods 8 and 12 over 96 cycles
    ha = 4; hb = 6;
    measure(96, -1, 0);
    check("p8_count_a", count_a, 12);
    check("p8_count_b", count_b, 8);
    check("p8_resp", resp, 1);

    // Identical period 10 over 100 cycles: tie
    ha = 5; hb = 5;
    measure(100, -1, 0);
    check("p10_count_a", count_a, 10);
    check("p10_tie", tie, 1);
    check("p10_resp", resp, 0);

    // Zero window
    ha = 3; hb = 2;
    measure(0, -1, 0);
    check("w0_count_a", count_a, 0);
    check("w0_tie", tie, 1);

    // Extra start during COUNT and start in the DONE cycle
    ha = 7; hb = 3;
    measure(50, SS + 20, 1);

    // Overflow: 20 edges on a 4-bit counter
    ha = 2; hb = 5;
    measure(80, -1, 0);
`ifdef ROCNT_SAT_EN
    check("ovf_count_a", count_a, 15);
`else
    check("ovf_count_a", count_a, 4);
`endif
    check("ovf_flag", ovf, 1);

    // Reset in the middle of COUNT
    begin
      int pulses = 0;
      ha = 4; hb = 3;
      measure(96, -1, 0);   // leave non-zero results behind
      start = 1'b1; window = WIN_W'(40);
      drive_ro(); next_cycle();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin drive_ro(); next_cycle(); end
      rst_n = 1'b0;
      drive_ro(); next_cycle();
      rst_n = 1'b1;
      check("midrst_busy", busy, 0);
      check("midrst_count_a", count_a, 0);
      check("midrst_count_b", count_b, 0);
      check("midrst_resp", resp, 0);
      check("midrst_tie", tie, 0);
      check("midrst_ovf", ovf, 0);
      for (int i = 0; i < 60; i++) begin
        if (done || busy) pulses++;
        drive_ro(); next_cycle();
      end
      check("midrst_no_done", pulses, 0);
      last_a = 0; last_b = 0; last_ovf = 0;
    end

    // Randomized measurements
    for (int t = 0; t < 30; t++) begin
      int w;
      ha = $urandom_range(0, 6);
      hb = $urandom_range(0, 6);
      w  = $urandom_range(0, 60);
      measure(w, ($urandom_range(0, 1) == 1) ? $urandom_range(1, SS + 2 + w) : -1,
              $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Parametrised successor to the single-RO edge counter used in the RO-PUF datapath.
- Counts rising edges of two ring-oscillator outputs over a programmable window, all in one system clock domain, using synchronised, edge-detected RO inputs.
- Compares the two counts to produce one PUF response bit.
- Sits between the RO bank/mux and the response shift register; the controller drives one start pulse per challenge.

Parameters:
- CNT_W, 16, width of each edge counter and of count outputs.
- WIN_W, 16, width of the window-length input (window counted in clk cycles).
- SYNC_STAGES, 2, flops per RO synchroniser chain (legal range 2..4).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- ro_a  input  1  RO output A (asynchronous to clk).
- ro_b  input  1  RO output B (asynchronous to clk).
- start  input  1  single-cycle request to begin a measurement.
- window  input  WIN_W  measurement length in clk cycles; sampled on accepted start.
- busy  output  1  high from accepted start until done.
- done  output  1  single-cycle pulse when results are valid.
- count_a  output  CNT_W  edges counted on ro_a in the last measurement.
- count_b  output  CNT_W  edges counted on ro_b in the last measurement.
- resp  output  1  1 when count_a > count_b, else 0.
- tie  output  1  1 when count_a == count_b.
- ovf  output  1  1 if either counter overflowed during the last measurement.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; busy=0, done=0, count_a=count_b=0, resp=0, tie=0, ovf=0; synchronisers and edge-detect flops cleared to 0. Reset applies mid-measurement as well; the measurement is aborted and no done pulse is produced.
- Input conditioning: each RO input passes through a SYNC_STAGES flop chain plus one history flop. An edge is registered when sync_out=1 and hist=0. Correct counting requires f_ro < f_clk/2; faster ROs alias, and this is a system constraint, not checked in RTL.
- FSM states:
  - IDLE: start=1 latches window into win_reg, clears internal counters and ovf, sets busy=1, and goes to SETTLE. start=0 keeps IDLE.
  - SETTLE: lasts SYNC_STAGES+1 cycles to flush stale synchroniser contents; no counting. Then goes to COUNT, or to DONE directly if win_reg==0.
  - COUNT: lasts exactly win_reg cycles. Each cycle, each counter increments by 1 if its edge was detected. The edge-detect output of the last COUNT cycle is included; edges arriving after it are not.
  - DONE: one cycle. Sets done=1 and loads count_a/count_b/resp/tie/ovf from the internal counters. busy drops to 0 in the same cycle. Next state is IDLE.
- Latency: with start accepted at cycle 0, done is high at cycle SYNC_STAGES+2+window.
- start while busy=1 is ignored (no restart, no queue). start in the DONE cycle is also ignored; it is accepted only in IDLE.
- Outputs hold their last values until the next DONE or reset; they do not change during a measurement.
- Counter overflow (default build): the counter wraps modulo 2^CNT_W and ovf sets sticky for the measurement.
- Simultaneous edges on A and B in one cycle: both counters increment.
- resp/tie are computed on the final counts; when tie=1, resp=0.

Optional Feature:
- Macro ROCNT_SAT_EN.
  - Defined: each counter saturates at 2^CNT_W-1 (no wrap). ovf sets when an edge arrives while the counter is already at max. resp/tie compare the saturated values.
  - Undefined: wrap-around as described under Behaviour; ovf still reports the wrap.

Test Plan:
- Reset mid-COUNT: drive rst_n=0 for 1 cycle -> next cycle busy=0, done never pulses, all outputs 0.
- ro_a toggling every 4 clk (period 8), ro_b every 6 clk (period 12), window=96 -> done at cycle SYNC_STAGES+98; count_a=12, count_b=8, resp=1, tie=0, ovf=0.
- ro_a=ro_b identical period 10, window=100 -> count_a=count_b=10, tie=1, resp=0.
- window=0 with toggling ROs -> done after SETTLE at cycle SYNC_STAGES+2; counts=0, tie=1.
- Second start pulse during COUNT -> ignored; only one done pulse; latency unchanged.
- CNT_W=4, ro_a period 4, window=80 (20 edges) -> default build: count_a=4, ovf=1. With ROCNT_SAT_EN: count_a=15, ovf=1.
